// File: rtl/wishbone_fifo_device.sv
// Wishbone classic responder in front of a synchronous FIFO.
// A write cycle pushes dat_i and a read cycle pops the head onto dat_o.
// Every termination (ack/err/rty) is registered, so none is ever asynchronous.
// A programmable number of wait states can be inserted before the response.
// A write to a full FIFO, or a read from an empty one, is answered with
// rty_o or err_o and leaves the FIFO untouched.
module wishbone_fifo_device #(
  parameter int DAT_WIDTH     = 8,
  parameter int DEPTH         = 16,
  parameter int WAIT_STATES   = 0,
  parameter int RETRY_NOT_ERR = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [DAT_WIDTH-1:0]       dat_i,
  output logic                       ack_o,
  output logic                       err_o,
  output logic                       rty_o,
  output logic [DAT_WIDTH-1:0]       dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam int WS_INIT = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]           state;
  logic [3:0]           wait_cnt;
  logic                 we_q;
  logic [DAT_WIDTH-1:0] wdat_q;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DAT_WIDTH-1:0] mem [DEPTH];

  logic req;
  logic cur_we;
  logic enter_resp;
  logic resp_ok;
  logic push;
  logic pop;

  assign req = cyc_i & stb_i;

  // In IDLE the direction has not been latched yet, so look at the bus.
  assign cur_we = (state == S_IDLE) ? we_i : we_q;

  assign enter_resp = req & (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                             ((state == S_WAIT) && (wait_cnt == 4'd0)));

  assign resp_ok = cur_we ? ~full_o : ~empty_o;

  // The FIFO only changes on the edge leaving RESP, and only if the
  // controller is still requesting and the transfer was acknowledged.
  assign push = (state == S_RESP) & ack_o & we_q  & req;
  assign pop  = (state == S_RESP) & ack_o & ~we_q & req;

  // Transaction sequencing: IDLE -> (WAIT ->) RESP -> IDLE, abort on dropped request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            we_q     <= we_i;
            wait_cnt <= 4'(WS_INIT);
            state    <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture write data together with the request; no reset needed on a data path.
  always_ff @(posedge clk_i) begin
    if ((state == S_IDLE) && req) begin
      wdat_q <= dat_i;
    end
  end

  // FIFO storage, written at the committing edge of an acknowledged write.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wdat_q;
    end
  end

  // One-cycle registered response, chosen on the edge entering RESP.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      rty_o <= 1'b0;
      dat_o <= '0;
      if (enter_resp) begin
        if (resp_ok) begin
          ack_o <= 1'b1;
          if (!cur_we) begin
            dat_o <= mem[rd_ptr];
          end
        end else if (RETRY_NOT_ERR != 0) begin
          rty_o <= 1'b1;
        end else begin
          err_o <= 1'b1;
        end
      end
    end
  end

  // Pointers and occupancy; push and pop never commit on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else if (push) begin
      wr_ptr  <= wr_ptr + AW'(1);
      count_o <= count_o + CW'(1);
      full_o  <= (count_o == CW'(DEPTH - 1));
      empty_o <= 1'b0;
    end else if (pop) begin
      rd_ptr  <= rd_ptr + AW'(1);
      count_o <= count_o - CW'(1);
      full_o  <= 1'b0;
      empty_o <= (count_o == CW'(1));
    end
  end

endmodule

// File: tb/tb_wishbone_fifo_device.sv
// Directed bench for wishbone_fifo_device.
// Instance 0: DEPTH=4, no wait states, full/empty answered with rty.
// Instance 1: DEPTH=4, three wait states, full/empty answered with err.
module tb_wishbone_fifo_device;

  logic       clk;
  logic       rst;
  logic       cyc_w [2];
  logic       stb_w [2];
  logic       we_w  [2];
  logic [7:0] dat_w [2];
  logic       ack_w [2];
  logic       err_w [2];
  logic       rty_w [2];
  logic [7:0] q_w   [2];
  logic [2:0] cnt_w [2];
  logic       full_w  [2];
  logic       empty_w [2];

  int errors = 0;
  int checks = 0;

  logic       r_ack;
  logic       r_err;
  logic       r_rty;
  logic [7:0] r_dat;
  int         r_lat;

  wishbone_fifo_device #(
    .DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(0), .RETRY_NOT_ERR(1)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_w[0]), .stb_i(stb_w[0]), .we_i(we_w[0]),
    .dat_i(dat_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]), .rty_o(rty_w[0]),
    .dat_o(q_w[0]), .count_o(cnt_w[0]), .full_o(full_w[0]), .empty_o(empty_w[0])
  );

  wishbone_fifo_device #(
    .DAT_WIDTH(8), .DEPTH(4), .WAIT_STATES(3), .RETRY_NOT_ERR(0)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc_w[1]), .stb_i(stb_w[1]), .we_i(we_w[1]),
    .dat_i(dat_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]), .rty_o(rty_w[1]),
    .dat_o(q_w[1]), .count_o(cnt_w[1]), .full_o(full_w[1]), .empty_o(empty_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete classic cycle: request held through the response edge and
  // the following (committing) edge, then released.
  task automatic xfer(input int i, input logic w, input logic [7:0] d);
    logic found;
    found = 1'b0;
    r_ack = 1'b0; r_err = 1'b0; r_rty = 1'b0; r_dat = 8'h00; r_lat = 0;
    @(negedge clk);
    cyc_w[i] = 1'b1; stb_w[i] = 1'b1; we_w[i] = w; dat_w[i] = d;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ack_w[i] || err_w[i] || rty_w[i]) begin
        found = 1'b1;
        r_lat = k;
        r_ack = ack_w[i]; r_err = err_w[i]; r_rty = rty_w[i]; r_dat = q_w[i];
        break;
      end
    end
    chk("resp_seen", 32'(found), 32'd1);
    chk("resp_exclusive", 32'(r_ack) + 32'(r_err) + 32'(r_rty), 32'd1);
    @(posedge clk); #1;
    chk("resp_one_cycle", {29'd0, ack_w[i], err_w[i], rty_w[i]}, 32'd0);
    chk("dat_o_cleared", 32'(q_w[i]), 32'd0);
    cyc_w[i] = 1'b0; stb_w[i] = 1'b0; we_w[i] = 1'b0;
  endtask

  initial begin
    int   ack_cyc [3];
    int   n;
    logic bad;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc_w[i] = 1'b0; stb_w[i] = 1'b0; we_w[i] = 1'b0; dat_w[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack_w[0]), 32'd0);
    chk("rst_err", 32'(err_w[0]), 32'd0);
    chk("rst_rty", 32'(rty_w[0]), 32'd0);
    chk("rst_dat", 32'(q_w[0]), 32'd0);
    chk("rst_count", 32'(cnt_w[0]), 32'd0);
    chk("rst_empty", 32'(empty_w[0]), 32'd1);
    chk("rst_full", 32'(full_w[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single write then read, zero wait states.
    xfer(0, 1'b1, 8'hA5);
    chk("w_a5_lat", 32'(r_lat), 32'd1);
    chk("w_a5_ack", 32'(r_ack), 32'd1);
    chk("w_a5_count", 32'(cnt_w[0]), 32'd1);
    chk("w_a5_empty", 32'(empty_w[0]), 32'd0);
    xfer(0, 1'b0, 8'h00);
    chk("r_a5_ack", 32'(r_ack), 32'd1);
    chk("r_a5_dat", 32'(r_dat), 32'hA5);
    chk("r_a5_count", 32'(cnt_w[0]), 32'd0);
    chk("r_a5_empty", 32'(empty_w[0]), 32'd1);

    // Read from empty FIFO answered with retry.
    xfer(0, 1'b0, 8'h00);
    chk("r_empty_rty", 32'(r_rty), 32'd1);
    chk("r_empty_ack", 32'(r_ack), 32'd0);
    chk("r_empty_count", 32'(cnt_w[0]), 32'd0);

    // Fill, overflow, drain in order.
    for (int v = 1; v <= 4; v++) begin
      xfer(0, 1'b1, 8'(v));
      chk("fill_ack", 32'(r_ack), 32'd1);
    end
    chk("fill_full", 32'(full_w[0]), 32'd1);
    chk("fill_count", 32'(cnt_w[0]), 32'd4);
    xfer(0, 1'b1, 8'h05);
    chk("ovf_rty", 32'(r_rty), 32'd1);
    chk("ovf_ack", 32'(r_ack), 32'd0);
    chk("ovf_count", 32'(cnt_w[0]), 32'd4);
    for (int v = 1; v <= 4; v++) begin
      xfer(0, 1'b0, 8'h00);
      chk("drain_dat", 32'(r_dat), 32'(v));
    end
    chk("drain_empty", 32'(empty_w[0]), 32'd1);
    chk("drain_full", 32'(full_w[0]), 32'd0);

    // Wrap-around with interleaved pairs.
    for (int v = 0; v < 10; v++) begin
      xfer(0, 1'b1, 8'(v));
      chk("wrap_count1", 32'(cnt_w[0]), 32'd1);
      xfer(0, 1'b0, 8'h00);
      chk("wrap_dat", 32'(r_dat), 32'(v));
      chk("wrap_count0", 32'(cnt_w[0]), 32'd0);
    end

    // Controller holds the request across three writes.
    n = 0;
    ack_cyc[0] = 0; ack_cyc[1] = 0; ack_cyc[2] = 0;
    @(negedge clk);
    cyc_w[0] = 1'b1; stb_w[0] = 1'b1; we_w[0] = 1'b1; dat_w[0] = 8'h30;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ack_w[0]) begin
        ack_cyc[n] = k;
        n++;
        dat_w[0] = 8'(8'h30 + n);
        if (n == 3) break;
      end
    end
    @(posedge clk); #1;
    cyc_w[0] = 1'b0; stb_w[0] = 1'b0; we_w[0] = 1'b0;
    chk("held_n", 32'(n), 32'd3);
    chk("held_ack0", 32'(ack_cyc[0]), 32'd1);
    chk("held_ack1", 32'(ack_cyc[1]), 32'd3);
    chk("held_ack2", 32'(ack_cyc[2]), 32'd5);
    chk("held_count", 32'(cnt_w[0]), 32'd3);
    for (int v = 0; v < 3; v++) begin
      xfer(0, 1'b0, 8'h00);
      chk("held_dat", 32'(r_dat), 32'(8'h30 + v));
    end

    // Three wait states: write then read of 0x11.
    xfer(1, 1'b1, 8'h11);
    chk("ws3_w_lat", 32'(r_lat), 32'd4);
    chk("ws3_w_ack", 32'(r_ack), 32'd1);
    xfer(1, 1'b0, 8'h00);
    chk("ws3_r_lat", 32'(r_lat), 32'd4);
    chk("ws3_r_ack", 32'(r_ack), 32'd1);
    chk("ws3_r_dat", 32'(r_dat), 32'h11);

    // Error flavour for empty read and full write.
    xfer(1, 1'b0, 8'h00);
    chk("ws3_empty_err", 32'(r_err), 32'd1);
    chk("ws3_empty_rty", 32'(r_rty), 32'd0);
    for (int v = 0; v < 4; v++) begin
      xfer(1, 1'b1, 8'(8'hB0 + v));
      chk("ws3_fill_ack", 32'(r_ack), 32'd1);
    end
    xfer(1, 1'b1, 8'hEE);
    chk("ws3_ovf_err", 32'(r_err), 32'd1);
    chk("ws3_ovf_lat", 32'(r_lat), 32'd4);
    chk("ws3_ovf_count", 32'(cnt_w[1]), 32'd4);

    // cyc_i dropped mid-WAIT: no response, no FIFO change.
    bad = 1'b0;
    @(negedge clk);
    cyc_w[1] = 1'b1; stb_w[1] = 1'b1; we_w[1] = 1'b0; dat_w[1] = 8'h77;
    @(posedge clk);
    @(posedge clk); #1;
    cyc_w[1] = 1'b0; stb_w[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (ack_w[1] || err_w[1] || rty_w[1]) bad = 1'b1;
    end
    chk("abort_no_resp", 32'(bad), 32'd0);
    chk("abort_count", 32'(cnt_w[1]), 32'd4);

    // Reset pulse mid-WAIT: outputs clear immediately, FIFO emptied.
    @(negedge clk);
    cyc_w[1] = 1'b1; stb_w[1] = 1'b1; we_w[1] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mrst_ack", 32'(ack_w[1]), 32'd0);
    chk("mrst_err", 32'(err_w[1]), 32'd0);
    chk("mrst_dat", 32'(q_w[1]), 32'd0);
    chk("mrst_count", 32'(cnt_w[1]), 32'd0);
    chk("mrst_empty", 32'(empty_w[1]), 32'd1);
    chk("mrst_full", 32'(full_w[1]), 32'd0);
    cyc_w[1] = 1'b0; stb_w[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Device is usable again after reset.
    xfer(1, 1'b1, 8'h5A);
    chk("post_rst_w_ack", 32'(r_ack), 32'd1);
    xfer(1, 1'b0, 8'h00);
    chk("post_rst_r_dat", 32'(r_dat), 32'h5A);
    chk("post_rst_count", 32'(cnt_w[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
